ac_scan_ctrl: RTL and testbench

- Sequencing controller for the combinational Aho-Corasick transition lookup (`a2p`).
- Accepts a framed byte stream and holds the current automaton state. Presents {2'b00, state, char} to the lookup each step.
- On a failed transition from a non-root state, retries the same character from root (state 0).
- Flags accepting states from a software-configured bitmap and reports match events with byte offset.
- Sits between the packet byte source and the lookup; match events go to the alert logic.

---
 rtl/ac_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ac_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_scan_ctrl.sv
// ac_scan_ctrl: steps an Aho-Corasick automaton one input byte at a time through an external lookup.
// Latency: 2 cycles per byte, or 3 when a failed transition is retried from root. Match and eop pulse on the resolving edge.
// Backpressure: in_ready is held low while a byte is in flight. Match and eop outputs cannot be stalled.
// Optional AC_SCAN_STATS_EN macro: adds stat_bytes, stat_matches and stat_retries counters (32-bit, wrapping).
module ac_scan_ctrl #(
    parameter int STATE_W = 8,
    parameter int CHAR_W  = 8,
    parameter int POS_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHAR_W-1:0]           in_data,
    input  logic                        in_last,
    output logic [STATE_W+CHAR_W+1:0]   lkp_din,
    input  logic [STATE_W+1:0]          lkp_dout,
    input  logic                        lkp_nvalid,
    input  logic                        cfg_we,
    input  logic [STATE_W-1:0]          cfg_addr,
    input  logic                        cfg_wdata,
`ifdef AC_SCAN_STATS_EN
    output logic [31:0]                 stat_bytes,
    output logic [31:0]                 stat_matches,
    output logic [31:0]                 stat_retries,
`endif
    output logic                        match_valid,
    output logic [STATE_W-1:0]          match_state,
    output logic [POS_W-1:0]            match_pos,
    output logic                        eop
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_STEP  = 2'd1,
        S_ROOT  = 2'd2
    } fsm_t;

    fsm_t                    fsm;
    logic [STATE_W-1:0]      cur_state;
    logic [CHAR_W-1:0]       ch_r;
    logic                    last_r;
    logic [POS_W-1:0]        pos;
    logic [2**STATE_W-1:0]   accept;

    logic                    resolve;
    logic [STATE_W-1:0]      new_state;
    logic                    hit;

    // Upper lookup output bits carry no information for the controller.
    logic                    unused_dout_hi;
    assign unused_dout_hi = ^lkp_dout[STATE_W+1:STATE_W];

    // Lookup address: current state in STEP, root in ROOT, char zeroed while idle.
    always_comb begin
        lkp_din = {2'b00, cur_state, {CHAR_W{1'b0}}};
        case (fsm)
            S_STEP:  lkp_din = {2'b00, cur_state, ch_r};
            S_ROOT:  lkp_din = {2'b00, {STATE_W{1'b0}}, ch_r};
            default: lkp_din = {2'b00, cur_state, {CHAR_W{1'b0}}};
        endcase
    end

    // Decide whether the byte in flight finishes this cycle and which state it lands in.
    // A miss at root is final; a miss elsewhere defers to the root retry.
    always_comb begin
        resolve   = 1'b0;
        new_state = '0;
        case (fsm)
            S_STEP: begin
                if (!lkp_nvalid) begin
                    resolve   = 1'b1;
                    new_state = lkp_dout[STATE_W-1:0];
                end else if (cur_state == '0) begin
                    resolve   = 1'b1;
                end
            end
            S_ROOT: begin
                resolve = 1'b1;
                if (!lkp_nvalid) begin
                    new_state = lkp_dout[STATE_W-1:0];
                end
            end
            default: begin
                resolve   = 1'b0;
                new_state = '0;
            end
        endcase
    end

    // The bitmap is read before any same-edge write lands, so a racing write applies to later bytes only.
    assign hit = resolve && (new_state != '0) && accept[new_state];

    // Main sequencer: byte fetch, lookup step, root retry and resolve bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= S_FETCH;
            in_ready    <= 1'b0;
            cur_state   <= '0;
            ch_r        <= '0;
            last_r      <= 1'b0;
            pos         <= '0;
            match_valid <= 1'b0;
            match_state <= '0;
            match_pos   <= '0;
            eop         <= 1'b0;
        end else begin
            match_valid <= 1'b0;
            eop         <= 1'b0;
            case (fsm)
                S_FETCH: begin
                    if (in_valid && in_ready) begin
                        ch_r     <= in_data;
                        last_r   <= in_last;
                        in_ready <= 1'b0;
                        fsm      <= S_STEP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (!resolve) begin
                        fsm <= S_ROOT;
                    end
                end
                S_ROOT: begin
                    fsm <= S_ROOT;
                end
                default: begin
                    fsm <= S_FETCH;
                end
            endcase

            if (resolve) begin
                cur_state <= new_state;
                if (hit) begin
                    match_valid <= 1'b1;
                    match_state <= new_state;
                    match_pos   <= pos;
                end
                if (last_r) begin
                    cur_state <= '0;
                    pos       <= '0;
                    eop       <= 1'b1;
                end else if (pos != {POS_W{1'b1}}) begin
                    pos <= pos + 1'b1;
                end
                in_ready <= 1'b1;
                fsm      <= S_FETCH;
            end
        end
    end

    // Accept bitmap; the root entry stays clear so the empty prefix never matches.
    always_ff @(posedge clk) begin
        if (rst) begin
            accept <= '0;
        end else if (cfg_we && (cfg_addr != '0)) begin
            accept[cfg_addr] <= cfg_wdata;
        end
    end

`ifdef AC_SCAN_STATS_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bytes   <= '0;
            stat_matches <= '0;
            stat_retries <= '0;
        end else begin
            if (resolve) begin
                stat_bytes <= stat_bytes + 32'd1;
            end
            if (hit) begin
                stat_matches <= stat_matches + 32'd1;
            end
            if ((fsm == S_STEP) && !resolve) begin
                stat_retries <= stat_retries + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ac_scan_ctrl.sv
// Bench for ac_scan_ctrl with a small goto-chain lookup model: state s accepts 'a'+s -> s+1, s < 8.
// Drives and samples on the falling edge; pulse monitor keeps cumulative counts.
// Directed packets cover chain match, root retry, root failure, packet boundary, config race and mid-byte reset.
module tb_ac_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [17:0] lkp_din;
    logic [9:0]  lkp_dout;
    logic        lkp_nvalid;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic        cfg_wdata;
    logic        match_valid;
    logic [7:0]  match_state;
    logic [15:0] match_pos;
    logic        eop;
`ifdef AC_SCAN_STATS_EN
    logic [31:0] stat_bytes;
    logic [31:0] stat_matches;
    logic [31:0] stat_retries;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    int n_match  = 0;
    int n_eop    = 0;
    int last_ms  = 0;
    int last_mp  = 0;
    int eop_cyc  = 0;

    ac_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .lkp_din     (lkp_din),
        .lkp_dout    (lkp_dout),
        .lkp_nvalid  (lkp_nvalid),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
`ifdef AC_SCAN_STATS_EN
        .stat_bytes  (stat_bytes),
        .stat_matches(stat_matches),
        .stat_retries(stat_retries),
`endif
        .match_valid (match_valid),
        .match_state (match_state),
        .match_pos   (match_pos),
        .eop         (eop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Lookup model: linear chain "abcdefgh", anything else is a miss.
    logic [7:0] lk_state;
    logic [7:0] lk_char;
    assign lk_state = lkp_din[15:8];
    assign lk_char  = lkp_din[7:0];
    always_comb begin
        lkp_nvalid = 1'b1;
        lkp_dout   = 10'd0;
        if ((lk_state < 8'd8) && (lk_char == 8'(8'h61 + lk_state))) begin
            lkp_nvalid = 1'b0;
            lkp_dout   = {2'b00, 8'(lk_state + 8'd1)};
        end
    end

    // Pulse monitor.
    always @(negedge clk) begin
        if (match_valid) begin
            n_match <= n_match + 1;
            last_ms <= int'(match_state);
            last_mp <= int'(match_pos);
        end
        if (eop) begin
            n_eop   <= n_eop + 1;
            eop_cyc <= cyc_cnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Sends one byte; reports cycles from handshake to next in_ready and the cycle count at handshake.
    // With race set, an accept[1]=1 write is held across the resolving edge.
    task automatic send_byte(input logic [7:0] c, input logic l, input logic race,
                             output int cyc, output int acc);
        int n;
        in_valid = 1'b1; in_data = c; in_last = l;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("handshake_timeout", 32'd0, 32'd1);
        acc = cyc_cnt;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        if (race) begin
            cfg_we = 1'b1; cfg_addr = 8'd1; cfg_wdata = 1'b1;
        end
        cyc = 1;
        n = 0;
        while (!in_ready && n < 50) begin
            cyc++;
            @(negedge clk);
            n++;
        end
        if (race) cfg_we = 1'b0;
        if (!in_ready) chk("resolve_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, acc, t0, m0, e0;
        string s;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        cfg_we = 1'b0; cfg_addr = 8'h00; cfg_wdata = 1'b0;
        cycles(3);

        // Reset state.
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_match_valid", 32'(match_valid), 32'd0);
        chk("rst_match_state", 32'(match_state), 32'd0);
        chk("rst_match_pos", 32'(match_pos), 32'd0);
        chk("rst_eop", 32'(eop), 32'd0);
        chk("rst_lkp_din", 32'(lkp_din), 32'd0);
        rst = 1'b0;
        chk("rst_release_ready_low", 32'(in_ready), 32'd0);
        cycles(1);
        chk("rst_release_ready_high", 32'(in_ready), 32'd1);

        // Chain "abcdefgh" with accept[8].
        cfg_write(8'd8, 1'b1);
        m0 = n_match; e0 = n_eop; t0 = 0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h61 + i), (i == 7), 1'b0, cyc, acc);
            if (i == 0) t0 = acc;
            s = $sformatf("t1_cyc_%0d", i);
            chk(s, 32'(cyc), 32'd2);
            s = $sformatf("t1_state_%0d", i);
            chk(s, 32'(lkp_din), (i == 7) ? 32'd0 : 32'((i + 1) << 8));
        end
        cycles(2);
        chk("t1_match_count", 32'(n_match - m0), 32'd1);
        chk("t1_match_state", 32'(last_ms), 32'd8);
        chk("t1_match_pos", 32'(last_mp), 32'd7);
        chk("t1_eop_count", 32'(n_eop - e0), 32'd1);
        chk("t1_eop_latency", 32'(eop_cyc - t0), 32'd16);

        // Root retry "aab".
        cfg_write(8'd2, 1'b1);
        m0 = n_match; e0 = n_eop;
        send_byte(8'h61, 1'b0, 1'b0, cyc, acc);
        chk("t2_a1_cyc", 32'(cyc), 32'd2);
        chk("t2_a1_state", 32'(lkp_din), 32'h100);
        send_byte(8'h61, 1'b0, 1'b0, cyc, acc);
        chk("t2_a2_cyc", 32'(cyc), 32'd3);
        chk("t2_a2_state", 32'(lkp_din), 32'h100);
        send_byte(8'h62, 1'b1, 1'b0, cyc, acc);
        chk("t2_b_cyc", 32'(cyc), 32'd2);
        cycles(2);
        chk("t2_match_count", 32'(n_match - m0), 32'd1);
        chk("t2_match_state", 32'(last_ms), 32'd2);
        chk("t2_match_pos", 32'(last_mp), 32'd2);
        chk("t2_eop_count", 32'(n_eop - e0), 32'd1);
        chk("t2_end_state", 32'(lkp_din), 32'd0);
`ifdef AC_SCAN_STATS_EN
        chk("t2_stat_retries", stat_retries, 32'd1);
        chk("t2_stat_bytes", stat_bytes, 32'd11);
        chk("t2_stat_matches", stat_matches, 32'd2);
`endif

        // Root failure "zzz".
        m0 = n_match; e0 = n_eop;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h7a, (i == 2), 1'b0, cyc, acc);
            s = $sformatf("t3_cyc_%0d", i);
            chk(s, 32'(cyc), 32'd2);
            s = $sformatf("t3_state_%0d", i);
            chk(s, 32'(lkp_din), 32'd0);
        end
        cycles(2);
        chk("t3_match_count", 32'(n_match - m0), 32'd0);
        chk("t3_eop_count", 32'(n_eop - e0), 32'd1);

        // Packet boundary: "ab"|last then "b"|last.
        m0 = n_match; e0 = n_eop;
        send_byte(8'h61, 1'b0, 1'b0, cyc, acc);
        send_byte(8'h62, 1'b1, 1'b0, cyc, acc);
        cycles(2);
        chk("t4_p1_match_count", 32'(n_match - m0), 32'd1);
        chk("t4_p1_match_state", 32'(last_ms), 32'd2);
        chk("t4_p1_match_pos", 32'(last_mp), 32'd1);
        chk("t4_p1_eop_count", 32'(n_eop - e0), 32'd1);
        send_byte(8'h62, 1'b1, 1'b0, cyc, acc);
        chk("t4_p2_cyc", 32'(cyc), 32'd2);
        cycles(2);
        chk("t4_p2_match_count", 32'(n_match - m0), 32'd1);
        chk("t4_p2_eop_count", 32'(n_eop - e0), 32'd2);

        // Config race: accept[1] written on the edge that resolves 'a'.
        m0 = n_match; e0 = n_eop;
        send_byte(8'h61, 1'b1, 1'b1, cyc, acc);
        cycles(2);
        chk("t5_race_match_count", 32'(n_match - m0), 32'd0);
        chk("t5_race_eop_count", 32'(n_eop - e0), 32'd1);
        send_byte(8'h61, 1'b1, 1'b0, cyc, acc);
        cycles(2);
        chk("t5_next_match_count", 32'(n_match - m0), 32'd1);
        chk("t5_next_match_state", 32'(last_ms), 32'd1);
        chk("t5_next_match_pos", 32'(last_mp), 32'd0);

        // Reset while a byte sits in S_STEP.
        m0 = n_match; e0 = n_eop;
        in_valid = 1'b1; in_data = 8'h61; in_last = 1'b1;
        chk("t6_pre_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_ready", 32'(in_ready), 32'd0);
        chk("t6_rst_match_valid", 32'(match_valid), 32'd0);
        chk("t6_rst_eop", 32'(eop), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_release_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t6_release_ready_high", 32'(in_ready), 32'd1);
        chk("t6_state_cleared", 32'(lkp_din), 32'd0);
        chk("t6_abort_match_count", 32'(n_match - m0), 32'd0);
        chk("t6_abort_eop_count", 32'(n_eop - e0), 32'd0);
        send_byte(8'h61, 1'b0, 1'b0, cyc, acc);
        chk("t6_a_state", 32'(lkp_din), 32'h100);
        send_byte(8'h7a, 1'b1, 1'b0, cyc, acc);
        chk("t6_z_cyc", 32'(cyc), 32'd3);
        cycles(2);
        chk("t6_bitmap_cleared", 32'(n_match - m0), 32'd0);
        chk("t6_eop_count", 32'(n_eop - e0), 32'd1);
        chk("t6_end_state", 32'(lkp_din), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
